memory_access_unit: RTL and testbench

- Executes load/store requests from the RV32I datapath against a word-wide synchronous data RAM.
- Requests arrive with the controller's 4-bit memory_control code.
- Handles byte and halfword lanes, sign/zero extension, and misaligned accesses that span two RAM words.
- Sits between the datapath/controller and the data RAM; raises busy so the core can stall.

---
 rtl/memory_access_unit_if.sv | 36 +++
 rtl/memory_access_unit.sv | 187 ++++++++++++++++++
 tb/tb_memory_access_unit.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_access_unit_if.sv
// Bundles the request/response handshake and the data-RAM bus of memory_access_unit.
//   master : the environment (datapath/controller and the data RAM). It drives start,
//            memory_control, address, write_data and ram_read_data.
//   slave  : the memory access unit. It drives read_data, busy, done and the RAM
//            address, strobe, lane mask and write data.
interface memory_access_unit_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                    start;
  logic [3:0]              memory_control;
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH-1:0]   write_data;
  logic [DATA_WIDTH-1:0]   read_data;
  logic                    busy;
  logic                    done;
  logic [ADDR_WIDTH-3:0]   ram_address;
  logic                    ram_write_enable;
  logic [DATA_WIDTH/8-1:0] ram_byte_enable;
  logic [DATA_WIDTH-1:0]   ram_write_data;
  logic [DATA_WIDTH-1:0]   ram_read_data;

  modport master (
    output start, memory_control, address, write_data, ram_read_data,
    input  read_data, busy, done, ram_address, ram_write_enable, ram_byte_enable,
           ram_write_data
  );

  modport slave (
    input  start, memory_control, address, write_data, ram_read_data,
    output read_data, busy, done, ram_address, ram_write_enable, ram_byte_enable,
           ram_write_data
  );

endinterface

// File: rtl/memory_access_unit.sv
// Load/store unit between the RV32I datapath and a word-wide synchronous data RAM.
// Handles byte/halfword/word lanes, sign/zero extension and misaligned accesses that
// straddle two RAM words (two writes for stores, two reads for loads).
// Ports:
//   clock  : rising-edge system clock
//   reset  : asynchronous active-low reset; aborts any access in flight
//   bus    : slave side of memory_access_unit_if
//            start/memory_control/address/write_data -> request (accepted in IDLE only)
//            read_data/busy/done                     -> result and status
//            ram_*                                   -> data RAM port (1-cycle read latency)
module memory_access_unit #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic                 clock,
  input logic                 reset,
  memory_access_unit_if.slave bus
);

  localparam int unsigned WordAddrWidth = ADDR_WIDTH - 2;

  typedef enum logic [2:0] {
    StIdle,
    StIssue0,
    StIssue1,
    StCapture0,
    StCapture1,
    StDone
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              ctrl_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   low_q;
  logic [DATA_WIDTH-1:0]   read_data_q;

  logic                    accept;
  logic                    is_store;
  logic                    is_unsigned;
  logic [1:0]              size;
  logic                    reserved;
  logic [1:0]              offset;
  logic [WordAddrWidth-1:0] w0, w1;
  logic [3:0]              mask;
  logic                    misaligned;
  logic [5:0]              bit_shift;
  logic [7:0]              mask_wide;
  logic [2*DATA_WIDTH-1:0] wdata_wide;
  logic [2*DATA_WIDTH-1:0] dword;
  logic [DATA_WIDTH-1:0]   slice;
  logic [DATA_WIDTH-1:0]   load_result;
  logic                    rd_update;

  assign accept      = (state_q == StIdle) && bus.start;
  assign is_store    = ctrl_q[3];
  assign is_unsigned = ctrl_q[2];
  assign size        = ctrl_q[1:0];
  assign reserved    = (size == 2'b11);
  assign offset      = addr_q[1:0];
  assign w0          = addr_q[ADDR_WIDTH-1:2];
  assign w1          = w0 + WordAddrWidth'(1);   // wraps modulo 2^30
  assign bit_shift   = {1'b0, offset, 3'b000};

  always_comb begin
    mask       = 4'b0000;
    misaligned = 1'b0;
    case (size)
      2'b00: mask = 4'b0001;
      2'b01: begin
        mask       = 4'b0011;
        misaligned = (offset == 2'd3);
      end
      2'b10: begin
        mask       = 4'b1111;
        misaligned = (offset != 2'd0);
      end
      default: ;
    endcase
  end

  // Lane-positioned mask and store data over two words: low half goes to w0, high half to w1.
  assign mask_wide  = {4'b0000, mask} << offset;
  assign wdata_wide = {{DATA_WIDTH{1'b0}}, wdata_q} << bit_shift;

  // The high word only exists once CAPTURE1 sees the second read; aligned loads finish from
  // CAPTURE0 with the first read still on the RAM port.
  assign dword = (state_q == StCapture1) ? {bus.ram_read_data, low_q}
                                         : {{DATA_WIDTH{1'b0}}, bus.ram_read_data};
  assign slice = dword[bit_shift +: DATA_WIDTH];

  always_comb begin
    load_result = '0;
    case (size)
      2'b00: load_result = {{(DATA_WIDTH-8){~is_unsigned & slice[7]}}, slice[7:0]};
      2'b01: load_result = {{(DATA_WIDTH-16){~is_unsigned & slice[15]}}, slice[15:0]};
      2'b10: load_result = slice;
      default: load_result = '0;
    endcase
  end

  // Stores leave read_data untouched; reserved-size requests of either kind clear it.
  assign rd_update = (state_d == StDone) && (!is_store || reserved);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      ctrl_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      low_q       <= '0;
      read_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ctrl_q  <= bus.memory_control;
        addr_q  <= bus.address;
        wdata_q <= bus.write_data;
      end
      if (state_q == StCapture0) begin
        low_q <= bus.ram_read_data;
      end
      if (rd_update) begin
        read_data_q <= load_result;
      end
    end
  end

  always_comb begin
    state_d              = state_q;
    bus.busy             = (state_q != StIdle);
    bus.done             = 1'b0;
    bus.ram_address      = '0;
    bus.ram_write_enable = 1'b0;
    bus.ram_byte_enable  = '0;
    bus.ram_write_data   = '0;
    bus.read_data        = read_data_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StIssue0;
        end
      end
      StIssue0: begin
        bus.ram_address = w0;
        if (reserved) begin
          state_d = StDone;
        end else begin
          bus.ram_byte_enable = mask_wide[3:0];
          if (is_store) begin
            bus.ram_write_enable = 1'b1;
            bus.ram_write_data   = wdata_wide[DATA_WIDTH-1:0];
            state_d              = misaligned ? StIssue1 : StDone;
          end else begin
            state_d = StCapture0;
          end
        end
      end
      StIssue1: begin
        bus.ram_address      = w1;
        bus.ram_byte_enable  = mask_wide[7:4];
        bus.ram_write_enable = 1'b1;
        bus.ram_write_data   = wdata_wide[2*DATA_WIDTH-1:DATA_WIDTH];
        state_d              = StDone;
      end
      StCapture0: begin
        // Present the second word now so its data arrives in CAPTURE1.
        if (misaligned) begin
          bus.ram_address = w1;
          state_d         = StCapture1;
        end else begin
          state_d = StDone;
        end
      end
      StCapture1: begin
        state_d = StDone;
      end
      StDone: begin
        bus.done = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_memory_access_unit.sv
module tb_memory_access_unit;

  logic clock = 1'b0;
  logic reset = 1'b0;

  memory_access_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  memory_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  mc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] exp_rd;
    int          exp_lat;
    bit          chk_rd;
  } exp_t;

  typedef struct {
    logic [29:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } wr_t;

  int checks = 0;
  int errors = 0;

  exp_t        sb[$];
  logic [29:0] trace[$];
  wr_t         wr_log[$];

  // RAM model: 256 words indexed by the low word-address bits, 1-cycle read latency.
  logic [31:0] mem [256];
  bit          loaded = 1'b0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    end
    return r;
  endfunction

  always @(posedge clock) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h40] <= 32'h8877_6655;
      mem[8'h41] <= 32'hCCBB_AA99;
      mem[8'hFF] <= 32'h1122_3344;
      mem[8'h00] <= 32'h5566_7788;
      loaded     <= 1'b1;
    end else begin
      bus.ram_read_data <= mem[bus.ram_address[7:0]];
      if (bus.ram_write_enable) begin
        mem[bus.ram_address[7:0]] <= merge(mem[bus.ram_address[7:0]], bus.ram_write_data,
                                           bus.ram_byte_enable);
      end
    end
  end

  always @(posedge clock) begin
    if (bus.ram_write_enable) begin
      wr_log.push_back('{bus.ram_address, bus.ram_byte_enable, bus.ram_write_data});
    end
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one request, push its expectation, wait (bounded) for done, pop and compare.
  // With hold=1, start stays high through busy and the DONE cycle.
  task automatic run_req(input string name, input logic [3:0] mc, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd,
                         input int exp_lat, input bit hold);
    exp_t e;
    int   k;
    e = '{exp_rd, exp_lat, (!mc[3] || mc[1:0] == 2'b11)};
    sb.push_back(e);
    trace.delete();
    wr_log.delete();
    @(negedge clock);
    bus.start          = 1'b1;
    bus.memory_control = mc;
    bus.address        = addr;
    bus.write_data     = wdata;
    @(posedge clock);
    #1;
    if (!hold) bus.start = 1'b0;
    k = 0;
    while (k < 12) begin
      @(negedge clock);
      trace.push_back(bus.ram_address);
      if (bus.done) break;
      k++;
    end
    e = sb.pop_front();
    if (k >= 12) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got no done expected done", name);
      bus.start = 1'b0;
    end else begin
      check32({name, " latency"}, 32'(k + 1), 32'(e.exp_lat));
      if (e.chk_rd) check32({name, " read_data"}, bus.read_data, e.exp_rd);
      @(negedge clock);
      check32({name, " idle"}, {31'b0, bus.busy}, 32'h0);
      bus.start = 1'b0;
      if (hold) begin
        @(negedge clock);
        check32({name, " no reaccept"}, {31'b0, bus.busy}, 32'h0);
      end
    end
  endtask

  vec_t vecs[12];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [29:0] ew0;
    logic [29:0] ew1;

    vecs[0]  = '{4'b0010, 32'h0000_0100, 32'h0, 32'h8877_6655, 3};
    vecs[1]  = '{4'b0000, 32'h0000_0103, 32'h0, 32'hFFFF_FF88, 3};
    vecs[2]  = '{4'b0100, 32'h0000_0103, 32'h0, 32'h0000_0088, 3};
    vecs[3]  = '{4'b0010, 32'h0000_0102, 32'h0, 32'hAA99_8877, 4};
    vecs[4]  = '{4'b0001, 32'h0000_0101, 32'h0, 32'h0000_7766, 3};
    vecs[5]  = '{4'b0001, 32'h0000_0103, 32'h0, 32'hFFFF_9988, 4};
    vecs[6]  = '{4'b0101, 32'h0000_0103, 32'h0, 32'h0000_9988, 4};
    vecs[7]  = '{4'b0000, 32'h0000_0105, 32'h0, 32'hFFFF_FFAA, 3};
    vecs[8]  = '{4'b0010, 32'h0000_0107, 32'h0, 32'h0000_00CC, 4};
    vecs[9]  = '{4'b0011, 32'h0000_0100, 32'h0, 32'h0000_0000, 2};
    vecs[10] = '{4'b0010, 32'hFFFF_FFFE, 32'h0, 32'h7788_1122, 4};
    vecs[11] = '{4'b1011, 32'h0000_0100, 32'hFFFF_FFFF, 32'h0000_0000, 2};

    bus.start          = 1'b0;
    bus.memory_control = 4'h0;
    bus.address        = 32'h0;
    bus.write_data     = 32'h0;

    // Reset state
    @(negedge clock);
    @(negedge clock);
    check32("rst busy", {31'b0, bus.busy}, 32'h0);
    check32("rst done", {31'b0, bus.done}, 32'h0);
    check32("rst read_data", bus.read_data, 32'h0);
    check32("rst we", {31'b0, bus.ram_write_enable}, 32'h0);
    check32("rst be", {28'b0, bus.ram_byte_enable}, 32'h0);
    check32("rst ram_address", {2'b0, bus.ram_address}, 32'h0);
    reset = 1'b1;
    @(negedge clock);

    // Table-driven loads and reserved-size requests; no RAM writes expected
    for (int i = 0; i < 12; i++) begin
      run_req($sformatf("vec%0d", i), vecs[i].mc, vecs[i].addr, vecs[i].wdata,
              vecs[i].exp_rd, vecs[i].exp_lat, 1'b0);
      ew0 = vecs[i].addr[31:2];
      ew1 = (vecs[i].exp_lat == 4) ? ew0 + 30'd1 : 30'd0;
      if (trace.size() >= 2) begin
        check32($sformatf("vec%0d word0", i), {2'b0, trace[0]}, {2'b0, ew0});
        check32($sformatf("vec%0d word1", i), {2'b0, trace[1]}, {2'b0, ew1});
      end
      check32($sformatf("vec%0d writes", i), wr_log.size(), 32'd0);
    end

    // Misaligned halfword store and readback
    run_req("sh_mis", 4'b1001, 32'h0000_0103, 32'h0000_BEEF, 32'h0, 3, 1'b0);
    check32("sh_mis writes", wr_log.size(), 32'd2);
    if (wr_log.size() == 2) begin
      check32("sh_mis w0 addr", {2'b0, wr_log[0].a}, 32'h40);
      check32("sh_mis w0 be", {28'b0, wr_log[0].be}, 32'h8);
      check32("sh_mis w0 byte", {24'b0, wr_log[0].d[31:24]}, 32'hEF);
      check32("sh_mis w1 addr", {2'b0, wr_log[1].a}, 32'h41);
      check32("sh_mis w1 be", {28'b0, wr_log[1].be}, 32'h1);
      check32("sh_mis w1 byte", {24'b0, wr_log[1].d[7:0]}, 32'hBE);
    end
    run_req("lw_100", 4'b0010, 32'h0000_0100, 32'h0, 32'hEF77_6655, 3, 1'b0);
    run_req("lw_104", 4'b0010, 32'h0000_0104, 32'h0, 32'hCCBB_AABE, 3, 1'b0);

    // Aligned word store, readback with start held high throughout
    run_req("sw_108", 4'b1010, 32'h0000_0108, 32'h1234_5678, 32'h0, 2, 1'b0);
    check32("sw_108 writes", wr_log.size(), 32'd1);
    if (wr_log.size() == 1) begin
      check32("sw_108 addr", {2'b0, wr_log[0].a}, 32'h42);
      check32("sw_108 be", {28'b0, wr_log[0].be}, 32'hF);
      check32("sw_108 data", wr_log[0].d, 32'h1234_5678);
    end
    run_req("lw_108_hold", 4'b0010, 32'h0000_0108, 32'h0, 32'h1234_5678, 3, 1'b1);
    run_req("sw_10c_hold", 4'b1010, 32'h0000_010C, 32'hCAFE_F00D, 32'h0, 2, 1'b1);
    check32("sw_10c_hold writes", wr_log.size(), 32'd1);

    // Reset asserted while the second half of a misaligned store is on the bus
    wr_log.delete();
    @(negedge clock);
    bus.start          = 1'b1;
    bus.memory_control = 4'b1010;
    bus.address        = 32'h0000_0101;
    bus.write_data     = 32'hDEAD_BEEF;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check32("abort pre we", {31'b0, bus.ram_write_enable}, 32'h1);
    check32("abort pre addr", {2'b0, bus.ram_address}, 32'h41);
    reset = 1'b0;
    #1;
    check32("abort we", {31'b0, bus.ram_write_enable}, 32'h0);
    check32("abort be", {28'b0, bus.ram_byte_enable}, 32'h0);
    check32("abort busy", {31'b0, bus.busy}, 32'h0);
    check32("abort done", {31'b0, bus.done}, 32'h0);
    check32("abort read_data", bus.read_data, 32'h0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check32("abort writes", wr_log.size(), 32'd1);
    check32("abort ram41", mem[8'h41], 32'hCCBB_AABE);
    check32("abort ram40", mem[8'h40], 32'hADBE_EF55);
    check32("abort idle", {31'b0, bus.busy}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
